// File: rtl/iq_dispatch_pkg.sv
// Instruction-queue entry types, class encodings and the issue-port structs
// shared by the dispatch stage and the reservation stations.
package sched_structs;
   localparam int NUM_ALU_UNITS = 5;

   typedef enum logic [1:0] {
      IQ_ALU  = 2'd0,
      IQ_CMP  = 2'd1,
      IQ_BR   = 2'd2,
      IQ_LDST = 2'd3
   } iq_cls_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [5:0]  rs1_tag;
      logic [5:0]  rs2_tag;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [31:0] pc;
   } iq_payload_t;

   typedef struct packed {
      iq_cls_e     cls;
      iq_payload_t payload;
   } iq_entry_t;

   typedef struct packed {
      logic        valid;
      iq_payload_t payload;
   } IQtoRS_ld_st_t;
endpackage

package rv_structs;
   // unit 0..4 are the ALU stations, unit 5 is the compare station
   typedef struct packed {
      logic                      valid;
      logic [2:0]                unit;
      logic                      slot;
      sched_structs::iq_payload_t payload;
   } IQtoRS_t;

   typedef struct packed {
      logic                      valid;
      sched_structs::iq_payload_t payload;
   } IQtoRS_br_t;
endpackage

// File: rtl/iq_dispatch_slot_select.sv
// Combinational priority picker: lowest free ALU unit/slot and lowest free CMP slot.
module rs_slot_select
   import sched_structs::*;
(
   input  logic [NUM_ALU_UNITS:0][1:0] status_i,
   output logic                        alu_free_o,
   output logic [2:0]                  alu_unit_o,
   output logic                        alu_slot_o,
   output logic                        cmp_free_o,
   output logic                        cmp_slot_o
);

   always_comb begin
      alu_free_o = 1'b0;
      alu_unit_o = '0;
      alu_slot_o = 1'b0;
      // walk downwards so the lowest-numbered free unit is the last one written
      for (int u = NUM_ALU_UNITS - 1; u >= 0; u--) begin
         if (status_i[u] != 2'b00) begin
            alu_free_o = 1'b1;
            alu_unit_o = 3'(u);
            alu_slot_o = ~status_i[u][0];
         end
      end
   end

   assign cmp_free_o = |status_i[NUM_ALU_UNITS];
   assign cmp_slot_o = ~status_i[NUM_ALU_UNITS][0];

endmodule

// File: rtl/iq_dispatch.sv
// In-order instruction queue: circular FIFO that issues its head to a free
// reservation-station slot of the matching class and allocates a ROB entry.
module iq_dispatch
   import sched_structs::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dec_valid,
   input  iq_entry_t                    dec_entry,
   output logic                         dec_ready,
   input  logic                         flush,
   input  logic                         rob_ready,
   input  logic [1:0]                   RS_unit1,
   input  logic [1:0]                   RS_unit2,
   input  logic [1:0]                   RS_unit3,
   input  logic [1:0]                   RS_unit4,
   input  logic [1:0]                   RS_unit5,
   input  logic [1:0]                   RS_unit_CMP_6,
   input  logic                         RS_unit_BR,
   input  logic                         RS_unit_ld_st,
   output rv_structs::IQtoRS_t          IQtoRS,
   output rv_structs::IQtoRS_br_t       IQtoRS_br,
   output IQtoRS_ld_st_t                IQtoRS_ld_st,
   output logic                         rob_alloc,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   iq_entry_t          mem_q [DEPTH];
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;

   iq_entry_t          head;
   logic               alu_free, alu_slot, cmp_free, cmp_slot;
   logic [2:0]         alu_unit;
   logic               tgt_free, fire, push;

   rs_slot_select u_sel (
      .status_i   ({RS_unit_CMP_6, RS_unit5, RS_unit4, RS_unit3, RS_unit2, RS_unit1}),
      .alu_free_o (alu_free),
      .alu_unit_o (alu_unit),
      .alu_slot_o (alu_slot),
      .cmp_free_o (cmp_free),
      .cmp_slot_o (cmp_slot)
   );

   assign head = mem_q[head_q];

   always_comb begin
      tgt_free = 1'b0;
      case (head.cls)
         IQ_ALU:  tgt_free = alu_free;
         IQ_CMP:  tgt_free = cmp_free;
         IQ_BR:   tgt_free = RS_unit_BR;
         IQ_LDST: tgt_free = RS_unit_ld_st;
         default: tgt_free = 1'b0;
      endcase
   end

   assign fire      = (count_q != '0) & valid_q[head_q] & rob_ready & tgt_free & ~flush;
   // a full queue still accepts when the head leaves in the same cycle
   assign dec_ready = ~rst & ~flush & ((count_q < CW'(DEPTH)) | fire);
   assign push      = dec_valid & dec_ready;
   assign rob_alloc = fire;
   assign count     = count_q;

   always_comb begin
      IQtoRS       = '0;
      IQtoRS_br    = '0;
      IQtoRS_ld_st = '0;
      if (fire) begin
         case (head.cls)
            IQ_ALU: begin
               IQtoRS.valid   = 1'b1;
               IQtoRS.unit    = alu_unit;
               IQtoRS.slot    = alu_slot;
               IQtoRS.payload = head.payload;
            end
            IQ_CMP: begin
               IQtoRS.valid   = 1'b1;
               IQtoRS.unit    = 3'(NUM_ALU_UNITS);
               IQtoRS.slot    = cmp_slot;
               IQtoRS.payload = head.payload;
            end
            IQ_BR: begin
               IQtoRS_br.valid   = 1'b1;
               IQtoRS_br.payload = head.payload;
            end
            default: begin
               IQtoRS_ld_st.valid   = 1'b1;
               IQtoRS_ld_st.payload = head.payload;
            end
         endcase
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         valid_d = '0;
      end else begin
         if (fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
         end
         // push after pop: a full-queue push reuses the slot the head just left
         if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
         end
         if (push & ~fire)      count_d = count_q + CW'(1);
         else if (fire & ~push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= dec_entry;
   end

endmodule

// File: tb/tb_iq_dispatch.sv
// Directed bench for iq_dispatch: reset, backpressure, head-of-line blocking,
// ROB stall, pointer wrap, flush and asynchronous reset.
module tb_iq_dispatch;
   import sched_structs::*;

   localparam int DEPTH   = 8;
   localparam int ENTRY_W = $bits(iq_entry_t);

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     dec_valid;
   iq_entry_t                dec_entry;
   logic                     dec_ready;
   logic                     flush;
   logic                     rob_ready;
   logic [1:0]               RS_unit1, RS_unit2, RS_unit3, RS_unit4, RS_unit5, RS_unit_CMP_6;
   logic                     RS_unit_BR, RS_unit_ld_st;
   rv_structs::IQtoRS_t      iq_rs;
   rv_structs::IQtoRS_br_t   iq_br;
   IQtoRS_ld_st_t            iq_ls;
   logic                     rob_alloc;
   logic [$clog2(DEPTH):0]   count;

   logic [ENTRY_W-1:0]       exp_q[$];
   int                       checks = 0;
   int                       errors = 0;
   logic [2:0]               exp_alu_unit;
   logic                     exp_alu_slot;
   logic                     exp_cmp_slot;

   iq_dispatch #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .dec_valid     (dec_valid),
      .dec_entry     (dec_entry),
      .dec_ready     (dec_ready),
      .flush         (flush),
      .rob_ready     (rob_ready),
      .RS_unit1      (RS_unit1),
      .RS_unit2      (RS_unit2),
      .RS_unit3      (RS_unit3),
      .RS_unit4      (RS_unit4),
      .RS_unit5      (RS_unit5),
      .RS_unit_CMP_6 (RS_unit_CMP_6),
      .RS_unit_BR    (RS_unit_BR),
      .RS_unit_ld_st (RS_unit_ld_st),
      .IQtoRS        (iq_rs),
      .IQtoRS_br     (iq_br),
      .IQtoRS_ld_st  (iq_ls),
      .rob_alloc     (rob_alloc),
      .count         (count)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic iq_entry_t mk(input logic [1:0] c, input logic [7:0] id);
      iq_entry_t e;
      e.cls             = iq_cls_e'(c);
      e.payload.opcode  = id[6:0];
      e.payload.rd      = id[4:0];
      e.payload.rs1_tag = id[5:0];
      e.payload.rs2_tag = ~id[5:0];
      e.payload.rs1_val = {24'h0, id};
      e.payload.rs2_val = {id, 24'hABCDEF};
      e.payload.imm     = 32'(id) * 32'd3;
      e.payload.pc      = 32'h8000_0000 + {22'h0, id, 2'b00};
      return e;
   endfunction

   task automatic set_rs(input logic [1:0] u1, input logic [1:0] u2, input logic [1:0] u3,
                         input logic [1:0] cmp, input logic br, input logic ls);
      RS_unit1 = u1; RS_unit2 = u2; RS_unit3 = u3; RS_unit4 = 2'b00; RS_unit5 = 2'b00;
      RS_unit_CMP_6 = cmp; RS_unit_BR = br; RS_unit_ld_st = ls;
   endtask

   task automatic chk_issue(input string tag, input logic exp_fire);
      iq_entry_t e;
      if (!exp_fire) begin
         chk({tag, "_rs_v"}, 256'(iq_rs.valid), 256'(0));
         chk({tag, "_br_v"}, 256'(iq_br.valid), 256'(0));
         chk({tag, "_ls_v"}, 256'(iq_ls.valid), 256'(0));
         chk({tag, "_rob"},  256'(rob_alloc),   256'(0));
      end else if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 256'(1), 256'(0));
      end else begin
         e = iq_entry_t'(exp_q.pop_front());
         chk({tag, "_rob"},  256'(rob_alloc), 256'(1));
         chk({tag, "_rs_v"}, 256'(iq_rs.valid), 256'(e.cls == IQ_ALU || e.cls == IQ_CMP));
         chk({tag, "_br_v"}, 256'(iq_br.valid), 256'(e.cls == IQ_BR));
         chk({tag, "_ls_v"}, 256'(iq_ls.valid), 256'(e.cls == IQ_LDST));
         case (e.cls)
            IQ_ALU: begin
               chk({tag, "_pl"},   256'(iq_rs.payload), 256'(e.payload));
               chk({tag, "_unit"}, 256'(iq_rs.unit), 256'(exp_alu_unit));
               chk({tag, "_slot"}, 256'(iq_rs.slot), 256'(exp_alu_slot));
            end
            IQ_CMP: begin
               chk({tag, "_pl"},   256'(iq_rs.payload), 256'(e.payload));
               chk({tag, "_unit"}, 256'(iq_rs.unit), 256'(5));
               chk({tag, "_slot"}, 256'(iq_rs.slot), 256'(exp_cmp_slot));
            end
            IQ_BR:   chk({tag, "_pl"}, 256'(iq_br.payload), 256'(e.payload));
            default: chk({tag, "_pl"}, 256'(iq_ls.payload), 256'(e.payload));
         endcase
      end
   endtask

   // one clock: inputs already driven; check issue and acceptance, then advance
   task automatic cycle(input string tag, input logic exp_fire, input logic exp_acc);
      #1;
      chk_issue(tag, exp_fire);
      if (dec_valid) begin
         chk({tag, "_rdy"}, 256'(dec_ready), 256'(exp_acc));
         if (exp_acc) exp_q.push_back(ENTRY_W'(dec_entry));
      end
      @(posedge clk);
      #1;
      dec_valid = 1'b0;
   endtask

   task automatic push_op(input string tag, input logic [1:0] c, input logic [7:0] id,
                          input logic exp_fire, input logic exp_acc);
      dec_valid = 1'b1;
      dec_entry = mk(c, id);
      cycle(tag, exp_fire, exp_acc);
   endtask

   initial begin
      rst = 1'b1; dec_valid = 1'b0; dec_entry = '0; flush = 1'b0; rob_ready = 1'b1;
      set_rs(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      exp_alu_unit = 3'd0; exp_alu_slot = 1'b0; exp_cmp_slot = 1'b0;

      // reset state
      #1;
      chk("rst_rdy", 256'(dec_ready), 256'(0));
      chk("rst_cnt", 256'(count), 256'(0));
      chk_issue("rst", 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("post_rst_rdy", 256'(dec_ready), 256'(1));
      chk("post_rst_cnt", 256'(count), 256'(0));
      @(posedge clk); #1;

      // basic: RS_unit2 slot 1 is the only free ALU slot
      set_rs(2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
      exp_alu_unit = 3'd1; exp_alu_slot = 1'b1;
      push_op("basic_push", 2'd0, 8'd1, 1'b0, 1'b1);
      chk("basic_cnt1", 256'(count), 256'(1));
      cycle("basic_issue", 1'b1, 1'b0);
      chk("basic_cnt0", 256'(count), 256'(0));

      // full / backpressure, head is a branch
      set_rs(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         push_op("fill", 2'((i + 2) % 4), 8'(10 + i), 1'b0, 1'b1);
      chk("full_cnt", 256'(count), 256'(8));
      push_op("full_9th", 2'd0, 8'd18, 1'b0, 1'b0);
      chk("full_cnt_hold", 256'(count), 256'(8));
      RS_unit_BR = 1'b1;
      push_op("full_pushpop", 2'd0, 8'd30, 1'b1, 1'b1);
      chk("full_cnt_same", 256'(count), 256'(8));
      set_rs(2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1);
      exp_alu_unit = 3'd0; exp_alu_slot = 1'b0; exp_cmp_slot = 1'b0;
      for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b1, 1'b0);
      chk("drain_cnt", 256'(count), 256'(0));

      // head-of-line blocking
      set_rs(2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      push_op("hol_push_ls", 2'd3, 8'd40, 1'b0, 1'b1);
      push_op("hol_push_alu", 2'd0, 8'd41, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle("hol_blocked", 1'b0, 1'b0);
      chk("hol_cnt", 256'(count), 256'(2));
      RS_unit_ld_st = 1'b1;
      cycle("hol_ls", 1'b1, 1'b0);
      cycle("hol_alu", 1'b1, 1'b0);
      chk("hol_cnt0", 256'(count), 256'(0));

      // ROB full stalls issue
      push_op("rob_push", 2'd0, 8'd50, 1'b0, 1'b1);
      rob_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle("rob_stall", 1'b0, 1'b0);
      chk("rob_cnt", 256'(count), 256'(1));
      rob_ready = 1'b1;
      cycle("rob_go", 1'b1, 1'b0);

      // wrap-around: 20 push/issue pairs, ALU lands on unit 2 slot 0, CMP on slot 1
      set_rs(2'b00, 2'b00, 2'b01, 2'b10, 1'b1, 1'b1);
      exp_alu_unit = 3'd2; exp_alu_slot = 1'b0; exp_cmp_slot = 1'b1;
      for (int i = 0; i < 20; i++)
         push_op("wrap", 2'((i * 3 + 1) % 4), 8'(60 + i), i != 0, 1'b1);
      chk("wrap_cnt", 256'(count), 256'(1));
      cycle("wrap_last", 1'b1, 1'b0);
      chk("wrap_cnt0", 256'(count), 256'(0));

      // flush with a same-cycle push and free stations
      set_rs(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) push_op("fl_fill", 2'd0, 8'(90 + i), 1'b0, 1'b1);
      chk("fl_cnt5", 256'(count), 256'(5));
      set_rs(2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1);
      exp_alu_unit = 3'd0; exp_alu_slot = 1'b0; exp_cmp_slot = 1'b0;
      flush = 1'b1;
      push_op("fl_push", 2'd0, 8'd99, 1'b0, 1'b0);
      flush = 1'b0;
      exp_q.delete();
      chk("fl_cnt0", 256'(count), 256'(0));
      cycle("fl_idle", 1'b0, 1'b0);
      push_op("fl_after", 2'd1, 8'd100, 1'b0, 1'b1);
      cycle("fl_after_iss", 1'b1, 1'b0);

      // asynchronous reset mid-stream
      set_rs(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push_op("ar_fill", 2'd0, 8'(110 + i), 1'b0, 1'b1);
      RS_unit1 = 2'b11;
      #1;
      chk("ar_pre_v", 256'(iq_rs.valid), 256'(1));
      #2 rst = 1'b1;
      #1;
      chk_issue("ar_in", 1'b0);
      chk("ar_in_rdy", 256'(dec_ready), 256'(0));
      chk("ar_in_cnt", 256'(count), 256'(0));
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      exp_q.delete();
      #1;
      chk_issue("ar_out", 1'b0);
      chk("ar_out_rdy", 256'(dec_ready), 256'(1));
      @(posedge clk); #1;
      push_op("ar_after", 2'd0, 8'd120, 1'b0, 1'b1);
      cycle("ar_after_iss", 1'b1, 1'b0);
      chk("ar_end_cnt", 256'(count), 256'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
